// File: rtl/cva6_shared_tlb_multilvl.sv
`default_nettype none
// ============================================================================
// Module   : cva6_shared_tlb_multilvl
// Purpose  : Set-associative shared L2 TLB sitting between the ITLB/DTLB and
//            the PTW. Round-robin ITLB/DTLB arbitration with req/gnt,
//            N-level superpage matching and an sfence.vma flush FSM
//            (full, ASID-selective, VA-selective, ASID+VA).
// Ports    : clk_i/rst_ni           clock, async active-low reset
//            itlb_*/dtlb_*          lookup request channels (req/vpn/gnt)
//            asid_i                 current ASID, sampled at grant
//            rsp_*                  lookup result, one cycle after grant
//            upd_*                  PTW refill
//            flush_*                sfence.vma request and qualifiers
//            flush_busy_o           flush FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module cva6_shared_tlb_multilvl #(
    parameter int SHARED_TLB_DEPTH = 64,
    parameter int SHARED_TLB_WAYS  = 2,
    parameter int ASID_WIDTH       = 9,
    parameter int VPN_LEVELS       = 2,
    parameter int VPN_LVL_WIDTH    = 10,
    parameter int PTE_WIDTH        = 32,
    localparam int c_VPN_W = VPN_LEVELS * VPN_LVL_WIDTH,
    localparam int c_LVL_W = (VPN_LEVELS > 1) ? $clog2(VPN_LEVELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  itlb_req_i,
    input  logic [c_VPN_W-1:0]    itlb_vpn_i,
    output logic                  itlb_gnt_o,
    input  logic                  dtlb_req_i,
    input  logic [c_VPN_W-1:0]    dtlb_vpn_i,
    output logic                  dtlb_gnt_o,
    input  logic [ASID_WIDTH-1:0] asid_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_is_itlb_o,
    output logic                  rsp_hit_o,
    output logic [c_VPN_W-1:0]    rsp_vpn_o,
    output logic [c_LVL_W-1:0]    rsp_level_o,
    output logic [PTE_WIDTH-1:0]  rsp_pte_o,
    input  logic                  upd_valid_i,
    input  logic [c_VPN_W-1:0]    upd_vpn_i,
    input  logic [ASID_WIDTH-1:0] upd_asid_i,
    input  logic [c_LVL_W-1:0]    upd_level_i,
    input  logic [PTE_WIDTH-1:0]  upd_pte_i,
    input  logic                  flush_i,
    input  logic                  flush_asid_en_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic                  flush_vaddr_en_i,
    input  logic [c_VPN_W-1:0]    flush_vpn_i,
    output logic                  flush_busy_o
);

    localparam int c_IDX_W     = $clog2(SHARED_TLB_DEPTH);
    localparam int c_WAY_W     = (SHARED_TLB_WAYS > 1) ? $clog2(SHARED_TLB_WAYS) : 1;
    localparam int c_CNT_W     = c_IDX_W + 1;
    localparam int c_PTE_G_BIT = 5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FLUSH_ALL = 3'd1,
        S_ONE_RD    = 3'd2,
        S_ONE_CMP   = 3'd3,
        S_SWEEP     = 3'd4
    } state_t;

    // Clear the VPN fields below page level lvl (superpage alignment).
    function automatic logic [c_VPN_W-1:0] f_mask(input logic [c_VPN_W-1:0] vpn, input int lvl);
        logic [c_VPN_W-1:0] m;
        m = vpn;
        for (int i = 0; i < c_VPN_W; i++) begin
            if (i < lvl * VPN_LVL_WIDTH) m[i] = 1'b0;
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 r_state, w_state_nxt;
    logic                   r_rr_dtlb;      // 0: ITLB wins a contended cycle
    logic [c_WAY_W-1:0]     r_repl_ptr;
    logic [c_CNT_W-1:0]     r_sweep_cnt;

    logic                   r_rsp_valid;
    logic                   r_rsp_is_itlb;
    logic [c_VPN_W-1:0]     r_rsp_vpn;
    logic [ASID_WIDTH-1:0]  r_asid_q;

    logic                   r_flush_asid_en;
    logic [ASID_WIDTH-1:0]  r_flush_asid;
    logic [c_VPN_W-1:0]     r_flush_vpn;

    logic [SHARED_TLB_WAYS-1:0] r_valid [SHARED_TLB_DEPTH];

    // Tag/PTE storage modelled as synchronous-read SRAM (no reset).
    logic [ASID_WIDTH-1:0]  r_tag_asid [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
    logic [c_VPN_W-1:0]     r_tag_vpn  [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
    logic [c_LVL_W-1:0]     r_tag_lvl  [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
    logic [PTE_WIDTH-1:0]   r_pte      [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];

    // One read port per page level: a level-k entry lives in the set indexed
    // by its aligned VPN, so a lookup probes each level's candidate set.
    logic [c_IDX_W-1:0]     w_rd_set  [VPN_LEVELS];
    logic [c_IDX_W-1:0]     r_rd_set  [VPN_LEVELS];
    logic [ASID_WIDTH-1:0]  r_rd_asid [VPN_LEVELS][SHARED_TLB_WAYS];
    logic [c_VPN_W-1:0]     r_rd_vpn  [VPN_LEVELS][SHARED_TLB_WAYS];
    logic [c_LVL_W-1:0]     r_rd_lvl  [VPN_LEVELS][SHARED_TLB_WAYS];
    logic [PTE_WIDTH-1:0]   r_rd_pte  [VPN_LEVELS][SHARED_TLB_WAYS];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                   w_arb_ok, w_both, w_gnt_i, w_gnt_d, w_gnt;
    logic [c_VPN_W-1:0]     w_gnt_vpn;

    assign w_arb_ok  = (r_state == S_IDLE) && !upd_valid_i;
    assign w_both    = itlb_req_i && dtlb_req_i;
    assign w_gnt_i   = w_arb_ok && itlb_req_i && (!dtlb_req_i || !r_rr_dtlb);
    assign w_gnt_d   = w_arb_ok && dtlb_req_i && (!itlb_req_i ||  r_rr_dtlb);
    assign w_gnt     = w_gnt_i || w_gnt_d;
    assign w_gnt_vpn = w_gnt_d ? dtlb_vpn_i : itlb_vpn_i;

    assign itlb_gnt_o = w_gnt_i;
    assign dtlb_gnt_o = w_gnt_d;

    // ------------------------------------------------------------------
    // Refill way selection: lowest invalid way, else replacement pointer
    // ------------------------------------------------------------------
    logic                   w_upd_we;
    logic [c_VPN_W-1:0]     w_upd_vpn_m;
    logic [c_IDX_W-1:0]     w_upd_set;
    logic                   w_free;
    logic [c_WAY_W-1:0]     w_free_way, w_upd_way;

    // A flush in the same cycle wins and the refill is dropped.
    assign w_upd_we    = upd_valid_i && (r_state == S_IDLE) && !flush_i;
    assign w_upd_vpn_m = f_mask(upd_vpn_i, int'(upd_level_i));
    assign w_upd_set   = w_upd_vpn_m[c_IDX_W-1:0];

    always_comb begin
        w_free     = 1'b0;
        w_free_way = '0;
        for (int w = SHARED_TLB_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_upd_set][w]) begin
                w_free     = 1'b1;
                w_free_way = c_WAY_W'(w);
            end
        end
        w_upd_way = w_free ? w_free_way : r_repl_ptr;
    end

    // ------------------------------------------------------------------
    // Read addresses
    // ------------------------------------------------------------------
    logic [c_VPN_W-1:0] w_rd_vpn;

    assign w_rd_vpn = (r_state == S_ONE_RD) ? r_flush_vpn : w_gnt_vpn;

    always_comb begin
        for (int k = 0; k < VPN_LEVELS; k++) begin
            w_rd_set[k] = f_mask(w_rd_vpn, k)
                [c_IDX_W-1:0];
        end
        // The sweep walks every set through port 0.
        if (r_state == S_SWEEP) w_rd_set[0] = r_sweep_cnt[c_IDX_W-1:0];
    end

    // ------------------------------------------------------------------
    // SRAM write / registered read
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_upd_we) begin
            r_tag_asid[w_upd_set][w_upd_way] <= upd_asid_i;
            r_tag_vpn [w_upd_set][w_upd_way] <= w_upd_vpn_m;
            r_tag_lvl [w_upd_set][w_upd_way] <= upd_level_i;
            r_pte     [w_upd_set][w_upd_way] <= upd_pte_i;
        end
        for (int k = 0; k < VPN_LEVELS; k++) begin
            for (int w = 0; w < SHARED_TLB_WAYS; w++) begin
                r_rd_asid[k][w] <= r_tag_asid[w_rd_set[k]][w];
                r_rd_vpn [k][w] <= r_tag_vpn [w_rd_set[k]][w];
                r_rd_lvl [k][w] <= r_tag_lvl [w_rd_set[k]][w];
                r_rd_pte [k][w] <= r_pte     [w_rd_set[k]][w];
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare: lookup hit, single-VA flush hit, ASID sweep hit
    // ------------------------------------------------------------------
    logic [VPN_LEVELS-1:0][SHARED_TLB_WAYS-1:0] w_lk_hit, w_fo_hit;
    logic [SHARED_TLB_WAYS-1:0]                 w_sw_hit;
    logic                                       w_hit;
    logic [c_LVL_W-1:0]                         w_hit_lvl;
    logic [PTE_WIDTH-1:0]                       w_hit_pte;

    always_comb begin
        w_lk_hit = '0;
        w_fo_hit = '0;
        w_sw_hit = '0;
        for (int k = 0; k < VPN_LEVELS; k++) begin
            for (int w = 0; w < SHARED_TLB_WAYS; w++) begin
                logic vld, g, lvl_ok;
                vld    = r_valid[r_rd_set[k]][w];
                g      = r_rd_pte[k][w][c_PTE_G_BIT];
                lvl_ok = (r_rd_lvl[k][w] == c_LVL_W'(k));
                w_lk_hit[k][w] = vld && lvl_ok
                              && ((r_rd_asid[k][w] == r_asid_q) || g)
                              && (r_rd_vpn[k][w] == f_mask(r_rsp_vpn, k));
                w_fo_hit[k][w] = vld && lvl_ok
                              && (r_rd_vpn[k][w] == f_mask(r_flush_vpn, k))
                              && (!r_flush_asid_en || ((r_rd_asid[k][w] == r_flush_asid) && !g));
            end
        end
        // Sweep compares the set read on the previous cycle; cnt 0 has none.
        for (int w = 0; w < SHARED_TLB_WAYS; w++) begin
            w_sw_hit[w] = (r_sweep_cnt != '0) && r_valid[r_rd_set[0]][w]
                       && (r_rd_asid[0][w] == r_flush_asid)
                       && !r_rd_pte[0][w][c_PTE_G_BIT];
        end
    end

    // Smallest page level first, then lowest way.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_lvl = '0;
        w_hit_pte = '0;
        for (int k = VPN_LEVELS - 1; k >= 0; k--) begin
            for (int w = SHARED_TLB_WAYS - 1; w >= 0; w--) begin
                if (w_lk_hit[k][w]) begin
                    w_hit     = 1'b1;
                    w_hit_lvl = c_LVL_W'(k);
                    w_hit_pte = r_rd_pte[k][w];
                end
            end
        end
    end

    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_is_itlb_o = r_rsp_valid && r_rsp_is_itlb;
    assign rsp_hit_o     = r_rsp_valid && w_hit;
    assign rsp_vpn_o     = r_rsp_valid ? r_rsp_vpn : '0;
    assign rsp_level_o   = (r_rsp_valid && w_hit) ? w_hit_lvl : '0;
    assign rsp_pte_o     = (r_rsp_valid && w_hit) ? w_hit_pte : '0;
    assign flush_busy_o  = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Flush FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (flush_i) begin
                    if (flush_vaddr_en_i)     w_state_nxt = S_ONE_RD;
                    else if (flush_asid_en_i) w_state_nxt = S_SWEEP;
                    else                      w_state_nxt = S_FLUSH_ALL;
                end
            end
            S_FLUSH_ALL: w_state_nxt = S_IDLE;
            S_ONE_RD:    w_state_nxt = S_ONE_CMP;
            S_ONE_CMP:   w_state_nxt = S_IDLE;
            S_SWEEP: begin
                if (r_sweep_cnt == c_CNT_W'(SHARED_TLB_DEPTH)) w_state_nxt = S_IDLE;
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and valid-bit registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= S_IDLE;
            r_rr_dtlb       <= 1'b0;
            r_repl_ptr      <= '0;
            r_sweep_cnt     <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_is_itlb   <= 1'b0;
            r_rsp_vpn       <= '0;
            r_asid_q        <= '0;
            r_flush_asid_en <= 1'b0;
            r_flush_asid    <= '0;
            r_flush_vpn     <= '0;
            for (int k = 0; k < VPN_LEVELS; k++) r_rd_set[k] <= '0;
            for (int i = 0; i < SHARED_TLB_DEPTH; i++) r_valid[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_gnt;
            for (int k = 0; k < VPN_LEVELS; k++) r_rd_set[k] <= w_rd_set[k];

            if (w_gnt) begin
                r_rsp_is_itlb <= w_gnt_i;
                r_rsp_vpn     <= w_gnt_vpn;
                r_asid_q      <= asid_i;
            end
            // Pointer only moves when both sides competed.
            if (w_gnt && w_both) r_rr_dtlb <= w_gnt_i;

            if ((r_state == S_IDLE) && flush_i) begin
                r_flush_asid_en <= flush_asid_en_i;
                r_flush_asid    <= flush_asid_i;
                r_flush_vpn     <= flush_vpn_i;
            end

            if (r_state == S_SWEEP) r_sweep_cnt <= r_sweep_cnt + 1'b1;
            else                    r_sweep_cnt <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_upd_we) begin
                        r_valid[w_upd_set][w_upd_way] <= 1'b1;
                        if (!w_free) begin
                            if (r_repl_ptr == c_WAY_W'(SHARED_TLB_WAYS - 1)) r_repl_ptr <= '0;
                            else r_repl_ptr <= r_repl_ptr + 1'b1;
                        end
                    end
                end
                S_FLUSH_ALL: begin
                    for (int i = 0; i < SHARED_TLB_DEPTH; i++) r_valid[i] <= '0;
                end
                S_ONE_CMP: begin
                    for (int k = 0; k < VPN_LEVELS; k++) begin
                        for (int w = 0; w < SHARED_TLB_WAYS; w++) begin
                            if (w_fo_hit[k][w]) r_valid[r_rd_set[k]][w] <= 1'b0;
                        end
                    end
                end
                S_SWEEP: begin
                    for (int w = 0; w < SHARED_TLB_WAYS; w++) begin
                        if (w_sw_hit[w]) r_valid[r_rd_set[0]][w] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cva6_shared_tlb_multilvl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cva6_shared_tlb_multilvl
// Purpose  : Directed self-checking bench for cva6_shared_tlb_multilvl
//            (default parameters: 64 sets, 2 ways, Sv32 layout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cva6_shared_tlb_multilvl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        itlb_req_i, dtlb_req_i;
    logic [19:0] itlb_vpn_i, dtlb_vpn_i;
    logic        itlb_gnt_o, dtlb_gnt_o;
    logic [8:0]  asid_i;
    logic        rsp_valid_o, rsp_is_itlb_o, rsp_hit_o;
    logic [19:0] rsp_vpn_o;
    logic [0:0]  rsp_level_o;
    logic [31:0] rsp_pte_o;
    logic        upd_valid_i;
    logic [19:0] upd_vpn_i;
    logic [8:0]  upd_asid_i;
    logic [0:0]  upd_level_i;
    logic [31:0] upd_pte_i;
    logic        flush_i, flush_asid_en_i, flush_vaddr_en_i;
    logic [8:0]  flush_asid_i;
    logic [19:0] flush_vpn_i;
    logic        flush_busy_o;

    int checks = 0;
    int errors = 0;

    // {valid, is_itlb, hit, level, pte} captured from the response cycle
    logic [35:0] cap;
    logic [19:0] cap_vpn;

    always #5 clk_i = ~clk_i;

    cva6_shared_tlb_multilvl dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .itlb_req_i       (itlb_req_i),
        .itlb_vpn_i       (itlb_vpn_i),
        .itlb_gnt_o       (itlb_gnt_o),
        .dtlb_req_i       (dtlb_req_i),
        .dtlb_vpn_i       (dtlb_vpn_i),
        .dtlb_gnt_o       (dtlb_gnt_o),
        .asid_i           (asid_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_is_itlb_o    (rsp_is_itlb_o),
        .rsp_hit_o        (rsp_hit_o),
        .rsp_vpn_o        (rsp_vpn_o),
        .rsp_level_o      (rsp_level_o),
        .rsp_pte_o        (rsp_pte_o),
        .upd_valid_i      (upd_valid_i),
        .upd_vpn_i        (upd_vpn_i),
        .upd_asid_i       (upd_asid_i),
        .upd_level_i      (upd_level_i),
        .upd_pte_i        (upd_pte_i),
        .flush_i          (flush_i),
        .flush_asid_en_i  (flush_asid_en_i),
        .flush_asid_i     (flush_asid_i),
        .flush_vaddr_en_i (flush_vaddr_en_i),
        .flush_vpn_i      (flush_vpn_i),
        .flush_busy_o     (flush_busy_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic idle_inputs();
        itlb_req_i = 0; dtlb_req_i = 0; itlb_vpn_i = '0; dtlb_vpn_i = '0; asid_i = '0;
        upd_valid_i = 0; upd_vpn_i = '0; upd_asid_i = '0; upd_level_i = '0; upd_pte_i = '0;
        flush_i = 0; flush_asid_en_i = 0; flush_asid_i = '0; flush_vaddr_en_i = 0; flush_vpn_i = '0;
    endtask

    task automatic refill(input logic [19:0] vpn, input logic [8:0] asid,
                          input logic lvl, input logic [31:0] pte);
        @(negedge clk_i);
        upd_valid_i = 1; upd_vpn_i = vpn; upd_asid_i = asid; upd_level_i = lvl; upd_pte_i = pte;
        @(negedge clk_i);
        upd_valid_i = 0;
    endtask

    // Issue one lookup, wait (bounded) for the grant, capture the response.
    task automatic lookup(input logic side_d, input logic [19:0] vpn, input logic [8:0] asid);
        logic got;
        @(negedge clk_i);
        asid_i = asid;
        if (side_d) begin dtlb_req_i = 1; dtlb_vpn_i = vpn; end
        else        begin itlb_req_i = 1; itlb_vpn_i = vpn; end
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (side_d ? dtlb_gnt_o : itlb_gnt_o) got = 1;
            else @(negedge clk_i);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout vpn=%h got no gnt, required gnt", vpn);
        end
        @(negedge clk_i);
        cap     = {rsp_valid_o, rsp_is_itlb_o, rsp_hit_o, rsp_level_o, rsp_pte_o};
        cap_vpn = rsp_vpn_o;
        itlb_req_i = 0; dtlb_req_i = 0;
    endtask

    // Pulse flush_i for one cycle and count the busy cycles that follow.
    task automatic do_flush(input logic asid_en, input logic [8:0] asid, input logic va_en,
                            input logic [19:0] vpn, output int busy_cycles);
        @(negedge clk_i);
        flush_i = 1; flush_asid_en_i = asid_en; flush_asid_i = asid;
        flush_vaddr_en_i = va_en; flush_vpn_i = vpn;
        @(negedge clk_i);
        flush_i = 0; flush_asid_en_i = 0; flush_vaddr_en_i = 0;
        busy_cycles = 0;
        while (flush_busy_o && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({itlb_gnt_o, dtlb_gnt_o, rsp_valid_o, rsp_hit_o, rsp_is_itlb_o, flush_busy_o} !== 6'b0
            || rsp_pte_o !== 32'h0 || rsp_vpn_o !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b%b valid=%b busy=%b pte=%h, required all 0",
                     itlb_gnt_o, dtlb_gnt_o, rsp_valid_o, flush_busy_o, rsp_pte_o);
        end
        rst_ni = 1;
        lookup(0, 20'h12345, 9'd3);
        checks++;
        if (cap !== {4'b1100, 32'h0}) begin
            errors++; $display("FAIL reset_empty got=%h required=%h", cap, {4'b1100, 32'h0});
        end
    endtask

    task automatic test_refill_hit();
        refill(20'h12345, 9'd3, 1'b0, 32'hCF);
        lookup(0, 20'h12345, 9'd3);
        checks++;
        if (cap !== {4'b1110, 32'hCF} || cap_vpn !== 20'h12345) begin
            errors++; $display("FAIL refill_hit got=%h vpn=%h required=%h vpn=12345", cap, cap_vpn, {4'b1110, 32'hCF});
        end
        lookup(1, 20'h12345, 9'd4);
        checks++;
        if (cap !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL asid_miss got=%h required=%h", cap, {4'b1000, 32'h0});
        end
    endtask

    task automatic test_round_robin();
        logic exp_i;
        @(negedge clk_i);
        asid_i = 9'd3;
        itlb_req_i = 1; itlb_vpn_i = 20'h12345;
        dtlb_req_i = 1; dtlb_vpn_i = 20'h00001;
        for (int i = 0; i < 4; i++) begin
            exp_i = (i % 2 == 0);
            #1;
            checks++;
            if ({itlb_gnt_o, dtlb_gnt_o} !== {exp_i, ~exp_i}) begin
                errors++; $display("FAIL rr_grant[%0d] got=%b%b required=%b%b", i, itlb_gnt_o, dtlb_gnt_o, exp_i, ~exp_i);
            end
            @(negedge clk_i);
            checks++;
            if ({rsp_valid_o, rsp_is_itlb_o, rsp_hit_o, rsp_pte_o} !== {1'b1, exp_i, exp_i, exp_i ? 32'hCF : 32'h0}) begin
                errors++; $display("FAIL rr_rsp[%0d] valid=%b itlb=%b hit=%b pte=%h required itlb=hit=%b",
                                   i, rsp_valid_o, rsp_is_itlb_o, rsp_hit_o, rsp_pte_o, exp_i);
            end
            if (i == 3) begin itlb_req_i = 0; dtlb_req_i = 0; end
        end
    endtask

    task automatic test_superpage();
        refill(20'h12C00, 9'd3, 1'b1, 32'hC7);
        lookup(0, 20'h12FFF, 9'd3);
        checks++;
        if (cap !== {4'b1111, 32'hC7}) begin
            errors++; $display("FAIL superpage_hit got=%h required=%h", cap, {4'b1111, 32'hC7});
        end
        lookup(1, 20'h13000, 9'd3);
        checks++;
        if (cap !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL superpage_out got=%h required=%h", cap, {4'b1000, 32'h0});
        end
    endtask

    task automatic test_replacement();
        refill(20'h00007, 9'd5, 1'b0, 32'h101);
        refill(20'h00047, 9'd5, 1'b0, 32'h202);
        refill(20'h00087, 9'd5, 1'b0, 32'h303);   // evicts way 0 (0x00007)
        lookup(1, 20'h00007, 9'd5);
        checks++;
        if (cap !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL repl_evict0 got=%h required=%h", cap, {4'b1000, 32'h0});
        end
        lookup(1, 20'h00047, 9'd5);
        checks++;
        if (cap !== {4'b1010, 32'h202}) begin
            errors++; $display("FAIL repl_keep1 got=%h required=%h", cap, {4'b1010, 32'h202});
        end
        refill(20'h000C7, 9'd5, 1'b0, 32'h404);   // pointer now 1: evicts 0x00047
        lookup(1, 20'h00047, 9'd5);
        checks++;
        if (cap !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL repl_evict1 got=%h required=%h", cap, {4'b1000, 32'h0});
        end
        lookup(1, 20'h000C7, 9'd5);
        checks++;
        if (cap !== {4'b1010, 32'h404}) begin
            errors++; $display("FAIL repl_new got=%h required=%h", cap, {4'b1010, 32'h404});
        end
        lookup(1, 20'h00087, 9'd5);
        checks++;
        if (cap !== {4'b1010, 32'h303}) begin
            errors++; $display("FAIL repl_way0 got=%h required=%h", cap, {4'b1010, 32'h303});
        end
    endtask

    task automatic test_asid_flush();
        int busy;
        refill(20'h00010, 9'd3, 1'b0, 32'h2F);    // global entry
        lookup(1, 20'h00010, 9'd4);
        checks++;
        if (cap !== {4'b1010, 32'h2F}) begin
            errors++; $display("FAIL global_other_asid got=%h required=%h", cap, {4'b1010, 32'h2F});
        end
        do_flush(1'b1, 9'd3, 1'b0, 20'h0, busy);
        checks++;
        if (busy != 65) begin
            errors++; $display("FAIL sweep_busy got=%0d required=65", busy);
        end
        lookup(0, 20'h00010, 9'd3);
        checks++;
        if (cap !== {4'b1110, 32'h2F}) begin
            errors++; $display("FAIL sweep_global_kept got=%h required=%h", cap, {4'b1110, 32'h2F});
        end
        lookup(0, 20'h12345, 9'd3);
        checks++;
        if (cap !== {4'b1100, 32'h0}) begin
            errors++; $display("FAIL sweep_nonglobal got=%h required=%h", cap, {4'b1100, 32'h0});
        end
        lookup(0, 20'h12FFF, 9'd3);
        checks++;
        if (cap !== {4'b1100, 32'h0}) begin
            errors++; $display("FAIL sweep_superpage got=%h required=%h", cap, {4'b1100, 32'h0});
        end
        lookup(1, 20'h00087, 9'd5);
        checks++;
        if (cap !== {4'b1010, 32'h303}) begin
            errors++; $display("FAIL sweep_other_asid got=%h required=%h", cap, {4'b1010, 32'h303});
        end
    endtask

    task automatic test_va_flush();
        int busy;
        refill(20'h00021, 9'd6, 1'b0, 32'h111);
        refill(20'h00022, 9'd6, 1'b0, 32'h242);
        do_flush(1'b0, 9'd0, 1'b1, 20'h00021, busy);
        checks++;
        if (busy != 2) begin
            errors++; $display("FAIL va_busy got=%0d required=2", busy);
        end
        lookup(1, 20'h00021, 9'd6);
        checks++;
        if (cap !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL va_target got=%h required=%h", cap, {4'b1000, 32'h0});
        end
        lookup(1, 20'h00022, 9'd6);
        checks++;
        if (cap !== {4'b1010, 32'h242}) begin
            errors++; $display("FAIL va_neighbour got=%h required=%h", cap, {4'b1010, 32'h242});
        end
        // Refill coinciding with flush_i must be dropped.
        @(negedge clk_i);
        upd_valid_i = 1; upd_vpn_i = 20'h00033; upd_asid_i = 9'd6; upd_level_i = 0; upd_pte_i = 32'h133;
        flush_i = 1; flush_vaddr_en_i = 1; flush_vpn_i = 20'h00055;
        @(negedge clk_i);
        upd_valid_i = 0; flush_i = 0; flush_vaddr_en_i = 0;
        for (int c = 0; c < 10 && flush_busy_o; c++) @(negedge clk_i);
        lookup(1, 20'h00033, 9'd6);
        checks++;
        if (cap !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL flush_vs_refill got=%h required=%h", cap, {4'b1000, 32'h0});
        end
    endtask

    task automatic test_full_flush_and_reset();
        int busy;
        do_flush(1'b0, 9'd0, 1'b0, 20'h0, busy);
        checks++;
        if (busy != 1) begin
            errors++; $display("FAIL full_busy got=%0d required=1", busy);
        end
        lookup(1, 20'h00010, 9'd3);
        checks++;
        if (cap !== {4'b1000, 32'h0}) begin
            errors++; $display("FAIL full_global got=%h required=%h", cap, {4'b1000, 32'h0});
        end
        // Reset in the middle of a sweep.
        refill(20'h00022, 9'd6, 1'b0, 32'h242);
        @(negedge clk_i);
        flush_i = 1; flush_asid_en_i = 1; flush_asid_i = 9'd9;
        @(negedge clk_i);
        flush_i = 0; flush_asid_en_i = 0;
        repeat (3) @(negedge clk_i);
        rst_ni = 0;
        #1;
        checks++;
        if (flush_busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_flush busy=%b required=0", flush_busy_o);
        end
        @(negedge clk_i);
        rst_ni = 1;
        lookup(0, 20'h00022, 9'd6);
        checks++;
        if (cap !== {4'b1100, 32'h0}) begin
            errors++; $display("FAIL reset_clears got=%h required=%h", cap, {4'b1100, 32'h0});
        end
    endtask

    initial begin
        test_reset();
        test_refill_hit();
        test_round_robin();
        test_superpage();
        test_replacement();
        test_asid_flush();
        test_va_flush();
        test_full_flush_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
